// File: rtl/evt_sched_pkg.sv
// Shared types and helpers for the windowed event-rate scheduler.
package evt_sched_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } sched_state_t;

    // Counts up by one unless already at max_val. Widths up to 32 bits are supported.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic        inc,
                                            input logic [31:0] max_val);
        logic [31:0] res;
        res = val;
        if (inc && (val != max_val)) begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/evt_sat_counter.sv
// One channel of the scheduler: a saturating event counter with a sticky saturation flag.
// The snapshot outputs already include the current cycle's event so a tick-cycle event lands
// in the closing window.
module evt_sat_counter
    import evt_sched_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               enable_in,
    input  logic               evt_in,
    input  logic               clear_in,
    output logic [COUNT_W-1:0] snap_cnt_out,
    output logic               snap_sat_out
);

    localparam logic [31:0] MAX_CNT = 32'((64'd1 << COUNT_W) - 64'd1);

    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               sat_q, sat_d;

    always_comb begin
        snap_cnt_out = cnt_q;
        snap_sat_out = sat_q;
        if (enable_in) begin
            snap_cnt_out = COUNT_W'(sat_inc(32'(cnt_q), evt_in, MAX_CNT));
            snap_sat_out = sat_q | (evt_in && (32'(cnt_q) == MAX_CNT));
        end

        cnt_d = snap_cnt_out;
        sat_d = snap_sat_out;
        if (!enable_in || clear_in) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

endmodule

// File: rtl/evt_window_sched.sv
// Window timer, per-channel counters, snapshot shadow registers and the report-burst FSM.
// Every window boundary snapshots all channels and streams them out as (chan, count) beats.
module evt_window_sched
    import evt_sched_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned WINDOW_CYCLES = 100_000,
    parameter int unsigned COUNT_W       = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    enable_in,
    input  logic [N_CH-1:0]         evt_in,
    input  logic                    rpt_ready_in,
    output logic                    rpt_valid_out,
    output logic [$clog2(N_CH)-1:0] rpt_chan_out,
    output logic [COUNT_W-1:0]      rpt_count_out,
    output logic                    rpt_sat_out,
    output logic                    rpt_last_out,
    output logic                    overrun_out
);

    localparam int unsigned          CH_W      = $clog2(N_CH);
    localparam int unsigned          TIMER_W   = $clog2(WINDOW_CYCLES);
    localparam logic [TIMER_W-1:0]   TIMER_MAX = TIMER_W'(WINDOW_CYCLES - 1);
    localparam logic [CH_W-1:0]      LAST_CH   = CH_W'(N_CH - 1);

    logic [TIMER_W-1:0]               timer_q, timer_d;
    sched_state_t                     state_q, state_d;
    logic [CH_W-1:0]                  idx_q, idx_d;
    logic [N_CH-1:0][COUNT_W-1:0]     shadow_cnt_q, shadow_cnt_d;
    logic [N_CH-1:0]                  shadow_sat_q, shadow_sat_d;
    logic                             overrun_q, overrun_d;
    logic                             rpt_valid_q, rpt_valid_d;
    logic [CH_W-1:0]                  rpt_chan_q, rpt_chan_d;
    logic [COUNT_W-1:0]               rpt_count_q, rpt_count_d;
    logic                             rpt_sat_q, rpt_sat_d;
    logic                             rpt_last_q, rpt_last_d;

    logic                             tick;
    logic [N_CH-1:0][COUNT_W-1:0]     snap_cnt;
    logic [N_CH-1:0]                  snap_sat;

    assign tick = enable_in && (timer_q == TIMER_MAX);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        evt_sat_counter #(
            .COUNT_W (COUNT_W)
        ) u_cnt (
            .clk_in       (clk_in),
            .rst_in       (rst_in),
            .enable_in    (enable_in),
            .evt_in       (evt_in[g]),
            .clear_in     (tick),
            .snap_cnt_out (snap_cnt[g]),
            .snap_sat_out (snap_sat[g])
        );
    end

    always_comb begin
        timer_d = '0;
        if (enable_in && (timer_q != TIMER_MAX)) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_cnt_d = shadow_cnt_q;
        shadow_sat_d = shadow_sat_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    shadow_cnt_d = snap_cnt;
                    shadow_sat_d = snap_sat;
                    idx_d        = '0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                // A boundary mid-burst drops the new snapshot to keep the in-flight burst intact.
                if (tick) begin
                    overrun_d = 1'b1;
                end
                if (rpt_ready_in) begin
                    if (idx_q == LAST_CH) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + CH_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        rpt_valid_d = (state_d == SEND);
        rpt_chan_d  = '0;
        rpt_count_d = '0;
        rpt_sat_d   = 1'b0;
        rpt_last_d  = 1'b0;
        if (rpt_valid_d) begin
            rpt_chan_d  = idx_d;
            rpt_count_d = shadow_cnt_d[idx_d];
            rpt_sat_d   = shadow_sat_d[idx_d];
            rpt_last_d  = (idx_d == LAST_CH);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            timer_q      <= '0;
            state_q      <= IDLE;
            idx_q        <= '0;
            shadow_cnt_q <= '0;
            shadow_sat_q <= '0;
            overrun_q    <= 1'b0;
            rpt_valid_q  <= 1'b0;
            rpt_chan_q   <= '0;
            rpt_count_q  <= '0;
            rpt_sat_q    <= 1'b0;
            rpt_last_q   <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            state_q      <= state_d;
            idx_q        <= idx_d;
            shadow_cnt_q <= shadow_cnt_d;
            shadow_sat_q <= shadow_sat_d;
            overrun_q    <= overrun_d;
            rpt_valid_q  <= rpt_valid_d;
            rpt_chan_q   <= rpt_chan_d;
            rpt_count_q  <= rpt_count_d;
            rpt_sat_q    <= rpt_sat_d;
            rpt_last_q   <= rpt_last_d;
        end
    end

    assign rpt_valid_out = rpt_valid_q;
    assign rpt_chan_out  = rpt_chan_q;
    assign rpt_count_out = rpt_count_q;
    assign rpt_sat_out   = rpt_sat_q;
    assign rpt_last_out  = rpt_last_q;
    assign overrun_out   = overrun_q;

endmodule

// File: doc/evt_window_sched.md
Name: evt_window_sched

Overview:
- Time-windowed event-rate scheduler for the Ethernet datapath: per-channel event counters share one window timer.
- At each window boundary it snapshots and clears every counter.
- Snapshots are serialized as (channel, count) reports over a valid/ready stream, for the stats/UART reporting path.
- Replaces free-running wrap counters with periodic, synchronously sampled per-window counts.

Parameters:
- N_CH, 4: number of event channels (>=2).
- WINDOW_CYCLES, 100_000: window length in clk_in cycles (>=N_CH+2).
- COUNT_W, 16: counter/report count width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; synchronous, active-high.
- enable_in  input  1  windowing enable.
- evt_in  input  N_CH  per-channel single-cycle event strobes.
- rpt_ready_in  input  1  downstream ready.
- rpt_valid_out  output  1  report valid.
- rpt_chan_out  output  $clog2(N_CH)  channel index of current report.
- rpt_count_out  output  COUNT_W  snapshot count for that channel.
- rpt_sat_out  output  1  that channel saturated during its window.
- rpt_last_out  output  1  high on the final channel (N_CH-1) of a report burst.
- overrun_out  output  1  sticky: window ended while a burst was still draining.

Behaviour:
- One clock, clk_in. Reset is synchronous and active-high on rst_in.
- Reset: timer=0, all counters/sat flags=0, shadow regs=0, FSM=IDLE. Outputs: rpt_valid_out=0, rpt_chan_out=0, rpt_count_out=0, rpt_sat_out=0, rpt_last_out=0, overrun_out=0.
- Timer: while enable_in, increments 0..WINDOW_CYCLES-1 then wraps to 0. tick = enable_in && timer==WINDOW_CYCLES-1.
- Counters: while enable_in, cnt[i] += evt_in[i].
  - Saturate at 2^COUNT_W-1; an event at saturation sets sat[i].
  - Events on different channels in the same cycle are all counted.
- Tick cycle with FSM IDLE:
  - shadow[i] <= cnt[i] + evt_in[i] (saturating), so an event on the tick cycle belongs to the closing window.
  - shadow_sat[i] captured the same way.
  - cnt[i] and sat[i] <= 0.
  - FSM -> SEND with idx=0.
- Tick cycle with FSM in SEND:
  - Counters and sat flags still clear.
  - The new snapshot is discarded; shadow regs are untouched, so the in-flight burst stays stable.
  - overrun_out <= 1, held until rst_in.
- FSM states: IDLE, SEND.
  - SEND: rpt_valid_out=1, rpt_chan_out=idx, rpt_count_out=shadow[idx], rpt_sat_out=shadow_sat[idx], rpt_last_out=(idx==N_CH-1).
  - On rpt_valid_out && rpt_ready_in: if idx==N_CH-1, go to IDLE (valid low next cycle); else idx+1.
  - Without ready, all rpt_* outputs hold stable (stream rule: valid never drops before acceptance).
- Latency: tick at cycle T gives the first report (chan 0) valid at T+1. With ready held high, a burst takes N_CH cycles.
- enable_in low:
  - Timer forced to 0, counters and sat flags held at 0, events ignored, no ticks.
  - An in-progress burst completes normally.
  - On re-enable, the first window is a full WINDOW_CYCLES.
- rst_in mid-burst: everything returns to reset values next cycle; the partial burst is abandoned with no last beat.

Decomposition:
- Package evt_sched_pkg holds:
  - typedef enum {IDLE, SEND} sched_state_t;
  - the localparam helper CH_W = $clog2(N_CH) (or computed in-module if package params are impractical);
  - the saturating-increment function.
- Natural sub-module: evt_sat_counter (one channel: saturating COUNT_W counter, sat flag, clear/snapshot interface). Instantiated N_CH times via generate; the top holds the timer, shadow regs and report FSM.

Test Plan (WINDOW_CYCLES=10, N_CH=4, COUNT_W=4):
- Reset then enable, evt_in[0] pulsed 3x, evt_in[2] 5x in window 1, ready=1 -> at cycle 10 reports (0,3),(1,0),(2,5),(3,0,last) on consecutive cycles; sat=0.
- evt_in[1] held high for the full window -> report (1,10); over two windows with no clear bug, each window reports 10. Separate run with COUNT_W=3: count saturates at 7, rpt_sat_out=1.
- Event on ch3 exactly on the tick cycle -> counted in the closing window's report; next window's ch3 report is 0.
- rpt_ready_in low for 15 cycles after first valid -> outputs stable on (0,x); second tick sets overrun_out=1. After ready rises, the old burst drains unchanged, then IDLE.
- enable_in dropped mid-window with events pending -> no report, counters 0. Re-enable: next report exactly 10 cycles later reflects only post-enable events.
- rst_in asserted while rpt_chan_out=2 -> next cycle rpt_valid_out=0, overrun_out=0, timer restarts from 0.
